// File: rtl/latch_mon_pkg.sv
// latch_mon_pkg: shared types and constants for the latch monitor
// Holds the FSM state encoding, default counter widths and the bit positions
// of the captured {d, en, q} vector reported by first_err_vec.
package latch_mon_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;
    localparam int CNT_W_DEF = 16;
    localparam int ERR_W_DEF = 8;
    localparam int VEC_W  = 3;
    localparam int VEC_Q  = 0;
    localparam int VEC_EN = 1;
    localparam int VEC_D  = 2;
endpackage

// File: rtl/latch_ref_model.sv
// latch_ref_model: golden positive-level latch with reset
// Ports: clk, rst (async monitor reset), d, en (gate), lrst (latch reset),
// q_exp (expected latch output for the current registered sample).
module latch_ref_model (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic en,
    input  logic lrst,
    output logic q_exp
);
    logic hold_q;
    // The latch is transparent, so the expectation for a sample is combinational;
    // hold_q only remembers the last value for the opaque phase.
    always_comb q_exp = lrst ? 1'b0 : (en ? d : hold_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= 1'b0;
        else     hold_q <= q_exp;
    end
endmodule

// File: rtl/latch_monitor.sv
// latch_monitor: checks a level-sensitive latch against a reference model
// Ports: clk, rst (async, active high); start/stop control pulses;
// dut_d, dut_en, dut_rst, dut_q observed latch signals;
// sample_cnt (compared samples), err_cnt (saturating mismatches),
// fail (sticky), done (DONE state), busy (ARMED or CHECK).
// Optional LATCH_MON_FIRST_ERR_EN adds first_err_idx and first_err_vec {d,en,q}.
module latch_monitor
    import latch_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dut_d,
    input  logic             dut_en,
    input  logic             dut_rst,
    input  logic             dut_q,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail,
    output logic             done,
    output logic             busy
`ifdef LATCH_MON_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [VEC_W-1:0] first_err_vec
`endif
);
    state_t state_q, state_d;
    logic rearm_q, rearm_d;
    logic d_q, en_q, lrst_q, obs_q, en_p_q, lrst_p_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic fail_q, fail_d;
    logic q_exp, mask, clr;
`ifdef LATCH_MON_FIRST_ERR_EN
    logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
    logic [VEC_W-1:0] fe_vec_q, fe_vec_d;
`endif

    latch_ref_model u_ref (
        .clk  (clk),
        .rst  (rst),
        .d    (d_q),
        .en   (en_q),
        .lrst (lrst_q),
        .q_exp(q_exp)
    );

    // Samples around a gate or reset edge are ambiguous, so they are skipped.
    assign mask = (en_q != en_p_q) || (lrst_q != lrst_p_q);

    always_comb begin
        state_d = state_q;
        rearm_d = rearm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        clr     = 1'b0;
`ifdef LATCH_MON_FIRST_ERR_EN
        fe_idx_d = fe_idx_q;
        fe_vec_d = fe_vec_q;
`endif
        case (state_q)
            IDLE: begin
                // rearm_q carries a DONE-time start through IDLE into ARMED
                if (start || rearm_q) begin
                    state_d = ARMED;
                    rearm_d = 1'b0;
                    clr     = start;
                end
            end
            ARMED: state_d = CHECK;
            CHECK: state_d = stop ? DONE : CHECK;
            DONE: begin
                if (start) begin
                    state_d = IDLE;
                    rearm_d = 1'b1;
                    clr     = 1'b1;
                end
            end
        endcase
        if (state_q == CHECK && !mask) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (obs_q != q_exp) begin
                err_d  = (err_q == '1) ? err_q : err_q + ERR_W'(1);
                fail_d = 1'b1;
`ifdef LATCH_MON_FIRST_ERR_EN
                if (!fail_q) begin
                    fe_idx_d         = cnt_q;
                    fe_vec_d[VEC_D]  = d_q;
                    fe_vec_d[VEC_EN] = en_q;
                    fe_vec_d[VEC_Q]  = obs_q;
                end
`endif
            end
        end
        if (clr) begin
            cnt_d  = '0;
            err_d  = '0;
            fail_d = 1'b0;
`ifdef LATCH_MON_FIRST_ERR_EN
            fe_idx_d = '0;
            fe_vec_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rearm_q  <= 1'b0;
            d_q      <= 1'b0;
            en_q     <= 1'b0;
            lrst_q   <= 1'b0;
            obs_q    <= 1'b0;
            en_p_q   <= 1'b0;
            lrst_p_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= '0;
            fail_q   <= 1'b0;
`ifdef LATCH_MON_FIRST_ERR_EN
            fe_idx_q <= '0;
            fe_vec_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rearm_q  <= rearm_d;
            d_q      <= dut_d;
            en_q     <= dut_en;
            lrst_q   <= dut_rst;
            obs_q    <= dut_q;
            en_p_q   <= en_q;
            lrst_p_q <= lrst_q;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
`ifdef LATCH_MON_FIRST_ERR_EN
            fe_idx_q <= fe_idx_d;
            fe_vec_q <= fe_vec_d;
`endif
        end
    end

    assign sample_cnt = cnt_q;
    assign err_cnt    = err_q;
    assign fail       = fail_q;
    assign done       = state_q == DONE;
    assign busy       = (state_q == ARMED) || (state_q == CHECK);
`ifdef LATCH_MON_FIRST_ERR_EN
    assign first_err_idx = fe_idx_q;
    assign first_err_vec = fe_vec_q;
`endif
endmodule

// File: tb/tb_latch_monitor.sv
// tb_latch_monitor: directed self-checking bench for latch_monitor
module tb_latch_monitor;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic dut_d = 1'b0, dut_en = 1'b0, dut_rst = 1'b0, dut_q = 1'b0;
    logic [15:0] sample_cnt;
    logic [7:0] err_cnt;
    logic fail, done, busy;
`ifdef LATCH_MON_FIRST_ERR_EN
    logic [15:0] first_err_idx;
    logic [2:0] first_err_vec;
`endif
    int n_vec = 0, n_err = 0;

    latch_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .dut_d     (dut_d),
        .dut_en    (dut_en),
        .dut_rst   (dut_rst),
        .dut_q     (dut_q),
        .sample_cnt(sample_cnt),
        .err_cnt   (err_cnt),
        .fail      (fail),
        .done      (done),
        .busy      (busy)
`ifdef LATCH_MON_FIRST_ERR_EN
        ,
        .first_err_idx(first_err_idx),
        .first_err_vec(first_err_vec)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic d, input logic en, input logic lr, input logic q);
        dut_d = d;
        dut_en = en;
        dut_rst = lr;
        dut_q = q;
        tick();
    endtask

    task automatic pulse(input logic s, input logic p);
        start = s;
        stop = p;
        tick();
        start = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_sample", 32'(sample_cnt), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);
        // good latch: reset phase, gate pulses, opaque hold, reopen
        pulse(1'b1, 1'b0);
        check("armed_busy", 32'(busy), 1);
        vec(0, 0, 1, 0);
        vec(0, 0, 1, 0);
        vec(1, 1, 0, 1);
        vec(1, 1, 0, 1);
        vec(1, 1, 0, 1);
        vec(1, 0, 0, 1);
        vec(0, 0, 0, 1);
        vec(0, 0, 0, 1);
        vec(1, 1, 0, 1);
        vec(1, 1, 0, 1);
        pulse(1'b0, 1'b1);
        check("good_done", 32'(done), 1);
        check("good_busy", 32'(busy), 0);
        check("good_sample", 32'(sample_cnt), 6);
        check("good_err", 32'(err_cnt), 0);
        check("good_fail", 32'(fail), 0);
        repeat (3) tick();
        check("done_hold", 32'(sample_cnt), 6);
        // start in DONE clears and re-arms via IDLE
        pulse(1'b1, 1'b0);
        check("clr_sample", 32'(sample_cnt), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_done", 32'(done), 0);
        tick();
        check("rearm_busy", 32'(busy), 1);
        repeat (3) vec(1, 1, 0, 0);
        pulse(1'b0, 1'b1);
        check("bad_err", 32'(err_cnt), 3);
        check("bad_fail", 32'(fail), 1);
        check("bad_sample", 32'(sample_cnt), 3);
`ifdef LATCH_MON_FIRST_ERR_EN
        check("first_vec", 32'(first_err_vec), 6);
        check("first_idx", 32'(first_err_idx), 0);
`endif
        // saturation
        pulse(1'b1, 1'b0);
        tick();
        repeat (300) vec(1, 1, 0, 0);
        pulse(1'b0, 1'b1);
        check("sat_err", 32'(err_cnt), 255);
        check("sat_sample", 32'(sample_cnt), 300);
        check("sat_fail", 32'(fail), 1);
        // gate toggling every cycle: everything masked
        pulse(1'b1, 1'b0);
        tick();
        check("clr_err", 32'(err_cnt), 0);
        for (int i = 0; i < 10; i++) vec(1, i[0], 0, 0);
        pulse(1'b0, 1'b1);
        check("mask_sample", 32'(sample_cnt), 0);
        check("mask_err", 32'(err_cnt), 0);
        check("mask_fail", 32'(fail), 0);
        // async reset mid-CHECK
        pulse(1'b1, 1'b0);
        tick();
        repeat (5) vec(1, 1, 0, 0);
        tick();
        check("mid_err", 32'(err_cnt), 5);
        check("mid_sample", 32'(sample_cnt), 5);
        check("mid_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #2;
        check("arst_sample", 32'(sample_cnt), 0);
        check("arst_err", 32'(err_cnt), 0);
        check("arst_fail", 32'(fail), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        dut_d = 1'b0;
        dut_en = 1'b0;
        dut_rst = 1'b0;
        dut_q = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        // start+stop together: start wins in IDLE, stop wins in CHECK
        pulse(1'b1, 1'b1);
        check("both_idle_busy", 32'(busy), 1);
        check("both_idle_done", 32'(done), 0);
        tick();
        pulse(1'b1, 1'b0);
        check("start_in_check_busy", 32'(busy), 1);
        check("start_in_check_done", 32'(done), 0);
        pulse(1'b1, 1'b1);
        check("both_check_done", 32'(done), 1);
        check("both_check_busy", 32'(busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/latch_monitor.md
LATCH_MONITOR -- requirements
Module: latch_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of the sample counter.
REQ-002 Parameter ERR_W, default 8, width of the error counter.
REQ-003 clk  input  1  sampling clock, rising-edge active; one clock domain only.
REQ-004 rst  input  1  asynchronous, active-high reset of the monitor.
REQ-005 start  input  1  single-cycle pulse that arms checking.
REQ-006 stop  input  1  single-cycle pulse that ends checking.
REQ-007 dut_d  input  1  data input of the positive-level latch under test.
REQ-008 dut_en  input  1  gate of the latch under test (transparent when 1).
REQ-009 dut_rst  input  1  reset of the latch under test (q forced 0 when 1).
REQ-010 dut_q  input  1  output of the latch under test.
REQ-011 sample_cnt  output  CNT_W  number of compared samples.
REQ-012 err_cnt  output  ERR_W  number of mismatches, saturating.
REQ-013 fail  output  1  sticky flag, set on the first mismatch.
REQ-014 done  output  1  high in the DONE state.
REQ-015 busy  output  1  high in the ARMED or CHECK state.

Function
REQ-016 Every dut_* input shall be registered once on each clk edge before use; all comparisons use only the registered copies.
REQ-017 The reference model shall compute q_exp from the registered inputs as follows.
- q_exp = 0 when dut_rst = 1.
- q_exp = dut_d when dut_rst = 0 and dut_en = 1.
- Otherwise q_exp holds its value.
REQ-018 The reference model shall update in every state, so it is valid when checking starts.
REQ-019 The state machine shall have four states, with these transitions:
- IDLE -> ARMED on start.
- ARMED -> CHECK on the next cycle.
- CHECK -> DONE on stop.
- DONE -> IDLE on start, which also clears the counters and re-enters ARMED on the following cycle.
REQ-020 In CHECK, a sample shall be compared unless it is masked under REQ-021.
- Each compared sample increments sample_cnt.
- A compared sample with dut_q != q_exp increments err_cnt and sets fail.
REQ-021 A sample shall be masked (neither counted nor compared) when registered dut_en or dut_rst differs from its value in the previous cycle.
REQ-022 err_cnt shall saturate at all-ones.
REQ-023 sample_cnt shall wrap from all-ones to 0 and shall not affect fail.
REQ-024 When start and stop are both high in one cycle, stop has priority in CHECK and start has priority in IDLE or DONE.
REQ-025 start while in ARMED or CHECK shall be ignored.
REQ-026 Counters and fail shall hold their values in DONE until the next start.

Reset
REQ-027 On rst the outputs shall reset as follows:
- sample_cnt = 0, err_cnt = 0.
- fail = 0, done = 0, busy = 0.
- State = IDLE.
- q_exp and all input registers = 0.
REQ-028 rst asserted mid-CHECK shall abort checking immediately, with no partial count retained.

Configuration
REQ-029 With LATCH_MON_FIRST_ERR_EN defined, the block shall add the output first_err_idx (CNT_W) and the output first_err_vec (3 bits: {d, en, q}).
- Both outputs capture the sample_cnt value and the registered inputs at the first mismatch.
- Both reset to 0 and clear on start.
REQ-030 Without LATCH_MON_FIRST_ERR_EN, these ports and their registers shall not exist, and all other behaviour shall be identical.

Structure
REQ-031 Package latch_mon_pkg shall hold the following:
- The state enumeration (IDLE, ARMED, CHECK, DONE).
- The default CNT_W and ERR_W constants.
- The first_err_vec bit-position constants.
REQ-032 The reference latch model shall be a separate sub-module, latch_ref_model, with ports clk, rst, d, en, lrst, q_exp.

Verification
REQ-033 Reset, then start; drive a correct latch with rst=1 for 12 ns, then d=1 and en toggling every 5 ns for 60 ns; then stop. Required: fail=0, err_cnt=0, sample_cnt>0, done=1.
REQ-034 Force dut_q=0 while dut_en=1 and dut_d=1 for 3 unmasked cycles. Required: err_cnt=3, fail=1, and with the macro defined first_err_vec=3'b110.
REQ-035 Hold a mismatch for 300 cycles with ERR_W=8. Required: err_cnt=255.
REQ-036 Toggle dut_en on every cycle while dut_q is wrong. Required: every sample masked, err_cnt=0, sample_cnt=0.
REQ-037 Assert rst mid-CHECK with err_cnt=5. Required: all outputs return to 0 asynchronously, state=IDLE.
REQ-038 Pulse start and stop together in CHECK, then in IDLE. Required: CHECK -> DONE; IDLE -> ARMED.
